// File: rtl/pool_seq.sv
// pool_seq: runs a pool engine through up to NUM_LAYERS configured layers per go request.
// Define POOL_SEQ_TIMEOUT_EN to add a TO_W-bit watchdog on the engine done handshake.
module pool_seq #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned TO_W       = 20
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_LAYERS)-1:0] cfg_idx,
    input  logic [5:0]                    cfg_flen,
    input  logic [8:0]                    cfg_in_channel,
    input  logic [$clog2(NUM_LAYERS):0]   cfg_num,
    input  logic                          go,
    input  logic                          abort,
    output logic                          pool_start,
    input  logic                          pool_done,
    output logic [5:0]                    flen,
    output logic [8:0]                    in_channel,
    output logic                          busy,
    output logic                          run_done,
    output logic                          err,
    output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
    output logic [31:0]                   total_cycles
);
    localparam int unsigned IDX_W  = $clog2(NUM_LAYERS);
    localparam int unsigned NUM_W  = IDX_W + 1;
    localparam int unsigned FLEN_W = 6;
    localparam int unsigned CH_W   = 9;
    localparam int unsigned TOT_W  = 32;

    if (NUM_LAYERS < 2 || TO_W < 2) begin : g_bad_params
        $error("pool_seq: NUM_LAYERS and TO_W must both be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT, RELEASE, NEXT, FINISH, ERROR
    } state_t;

    state_t              state, state_d;
    logic [FLEN_W-1:0]   flen_tab [NUM_LAYERS];
    logic [CH_W-1:0]     ch_tab   [NUM_LAYERS];
    logic [NUM_W-1:0]    num_q, num_d;
    logic                drain_q, drain_d;
    logic                pool_start_d, busy_d, run_done_d, err_d;
    logic [FLEN_W-1:0]   flen_d;
    logic [CH_W-1:0]     in_ch_d;
    logic [IDX_W-1:0]    cur_d, nxt_layer;
    logic [TOT_W-1:0]    total_d;
    logic                num_ok, last_layer;

`ifdef POOL_SEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] WDOG_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    logic [TO_W-1:0] wdog, wdog_d;
`endif

    assign num_ok     = (cfg_num != '0) && (32'(cfg_num) <= NUM_LAYERS);
    assign nxt_layer  = cur_layer + IDX_W'(1);
    assign last_layer = (NUM_W'(cur_layer) + NUM_W'(1)) == num_q;

    // Layer table: writable only while idle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                flen_tab[i] <= '0;
                ch_tab[i]   <= '0;
            end
        end else if (cfg_we && state == IDLE) begin
            flen_tab[cfg_idx] <= cfg_flen;
            ch_tab[cfg_idx]   <= cfg_in_channel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_d;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d      = state;
        pool_start_d = pool_start;
        flen_d       = flen;
        in_ch_d      = in_channel;
        cur_d        = cur_layer;
        err_d        = err;
        num_d        = num_q;
        drain_d      = drain_q;
        total_d      = busy ? ((total_cycles == '1) ? total_cycles : total_cycles + TOT_W'(1))
                            : total_cycles;
`ifdef POOL_SEQ_TIMEOUT_EN
        wdog_d       = wdog;
`endif
        unique case (state)
            IDLE, ERROR: begin
                if (go && !abort) begin
                    if (num_ok) begin
                        state_d = LOAD;
                        num_d   = cfg_num;
                        err_d   = 1'b0;
                        drain_d = 1'b0;
                        total_d = '0;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                cur_d   = '0;
                flen_d  = flen_tab[0];
                in_ch_d = ch_tab[0];
                state_d = START;
            end
            START: begin
                pool_start_d = 1'b1;
                state_d      = WAIT;
`ifdef POOL_SEQ_TIMEOUT_EN
                wdog_d       = '0;
`endif
            end
            WAIT: begin
                if (pool_done) begin
                    pool_start_d = 1'b0;
                    state_d      = RELEASE;
                end
`ifdef POOL_SEQ_TIMEOUT_EN
                else if (wdog == WDOG_LAST) begin
                    pool_start_d = 1'b0;
                    err_d        = 1'b1;
                    state_d      = ERROR;
                end else begin
                    wdog_d = wdog + TO_W'(1);
                end
`endif
            end
            RELEASE: begin
                if (!pool_done) begin
                    state_d = drain_q ? IDLE : NEXT;
                    drain_d = 1'b0;
                end
            end
            NEXT: begin
                if (last_layer) begin
                    state_d = FINISH;
                end else begin
                    cur_d   = nxt_layer;
                    flen_d  = flen_tab[nxt_layer];
                    in_ch_d = ch_tab[nxt_layer];
                    state_d = START;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort drains the engine handshake, then returns to IDLE without run_done
        if (abort && busy) begin
            pool_start_d = 1'b0;
            state_d      = RELEASE;
            drain_d      = 1'b1;
        end
        busy_d     = (state_d != IDLE) && (state_d != ERROR);
        run_done_d = (state_d == FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pool_start   <= 1'b0;
            flen         <= '0;
            in_channel   <= '0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            err          <= 1'b0;
            cur_layer    <= '0;
            total_cycles <= '0;
            num_q        <= '0;
            drain_q      <= 1'b0;
        end else begin
            pool_start   <= pool_start_d;
            flen         <= flen_d;
            in_channel   <= in_ch_d;
            busy         <= busy_d;
            run_done     <= run_done_d;
            err          <= err_d;
            cur_layer    <= cur_d;
            total_cycles <= total_d;
            num_q        <= num_d;
            drain_q      <= drain_d;
        end
    end

`ifdef POOL_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) wdog <= '0;
        else       wdog <= wdog_d;
    end
`endif

endmodule

// File: tb/tb_pool_seq.sv
// Self-checking bench for pool_seq: behavioural pool engine plus a layer-table model.
module tb_pool_seq;
    localparam int unsigned NL = 4;
    localparam int unsigned IW = $clog2(NL);
    localparam int unsigned NW = IW + 1;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [5:0]    cfg_flen = '0;
    logic [8:0]    cfg_in_channel = '0;
    logic [NW-1:0] cfg_num = '0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic          pool_start;
    logic          pool_done = 1'b0;
    logic [5:0]    flen;
    logic [8:0]    in_channel;
    logic          busy, run_done, err;
    logic [IW-1:0] cur_layer;
    logic [31:0]   total_cycles;

    pool_seq #(.NUM_LAYERS(NL), .TO_W(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_flen(cfg_flen), .cfg_in_channel(cfg_in_channel),
        .cfg_num(cfg_num), .go(go), .abort(abort),
        .pool_start(pool_start), .pool_done(pool_done), .flen(flen), .in_channel(in_channel),
        .busy(busy), .run_done(run_done), .err(err), .cur_layer(cur_layer),
        .total_cycles(total_cycles)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table and expected per-start configuration
    logic [5:0] m_flen [NL];
    logic [8:0] m_ch   [NL];
    logic [5:0] exp_flen_q [$];
    logic [8:0] exp_ch_q   [$];

    // Engine model knobs and run observations
    int   eng_lat = 0, eng_hold = 0, eng_cnt = 0, eng_hcnt = 0;
    bit   eng_dead = 1'b0;
    int   starts = 0, busy_cycles = 0, done_high = 0;
    logic prev_start = 1'b0;
    logic [5:0] cap_flen = '0;
    logic [8:0] cap_ch = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe DUT after the edge, then advance the engine model
    task automatic step();
        @(posedge CLK);
        #1;
        if (pool_start && !prev_start) begin
            starts++;
            check("start_while_done", 64'(pool_done), 64'd0);
            check("start_expected", 64'(exp_flen_q.size() != 0), 64'd1);
            if (exp_flen_q.size() != 0) begin
                check("start_flen", 64'(flen), 64'(exp_flen_q[0]));
                check("start_in_channel", 64'(in_channel), 64'(exp_ch_q[0]));
                void'(exp_flen_q.pop_front());
                void'(exp_ch_q.pop_front());
            end
            cap_flen = flen;
            cap_ch   = in_channel;
        end else if (pool_start) begin
            check("flen_stable", 64'(flen), 64'(cap_flen));
            check("in_channel_stable", 64'(in_channel), 64'(cap_ch));
        end
        if (busy) busy_cycles++;
        if (run_done) done_high++;
        prev_start = pool_start;

        if (pool_done) begin
            eng_hcnt++;
            if (!pool_start && eng_hcnt >= eng_hold) begin
                pool_done = 1'b0;
                eng_cnt   = 0;
            end
        end else if (pool_start && !eng_dead) begin
            if (eng_cnt >= eng_lat) begin
                pool_done = 1'b1;
                eng_hcnt  = 0;
            end else begin
                eng_cnt++;
            end
        end else begin
            eng_cnt = 0;
        end
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1;
        pool_done = 1'b0;
        eng_cnt = 0;
        step();
        RESET = 1'b0;
        check({tag, ":pool_start"}, 64'(pool_start), 64'd0);
        check({tag, ":busy"}, 64'(busy), 64'd0);
        check({tag, ":run_done"}, 64'(run_done), 64'd0);
        check({tag, ":err"}, 64'(err), 64'd0);
        check({tag, ":cur_layer"}, 64'(cur_layer), 64'd0);
        check({tag, ":total_cycles"}, 64'(total_cycles), 64'd0);
        check({tag, ":flen"}, 64'(flen), 64'd0);
        check({tag, ":in_channel"}, 64'(in_channel), 64'd0);
        for (int i = 0; i < NL; i++) begin
            m_flen[i] = '0;
            m_ch[i]   = '0;
        end
        exp_flen_q.delete();
        exp_ch_q.delete();
    endtask

    task automatic write_slot(input int idx, input int fl, input int ch);
        cfg_we = 1'b1;
        cfg_idx = IW'(idx);
        cfg_flen = 6'(fl);
        cfg_in_channel = 9'(ch);
        step();
        cfg_we = 1'b0;
        m_flen[idx] = 6'(fl);
        m_ch[idx]   = 9'(ch);
    endtask

    task automatic begin_run(input int num, input int lat, input int hold);
        exp_flen_q.delete();
        exp_ch_q.delete();
        for (int i = 0; i < num; i++) begin
            exp_flen_q.push_back(m_flen[i]);
            exp_ch_q.push_back(m_ch[i]);
        end
        starts = 0;
        busy_cycles = 0;
        done_high = 0;
        eng_lat = lat;
        eng_hold = hold;
        cfg_num = NW'(num);
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic run_layers(input int num, input int lat, input int hold, input bit noise,
                              input string tag);
        int t;
        begin_run(num, lat, hold);
        t = 0;
        while (!(done_high > 0 && !busy) && t < 2000) begin
            if (noise && busy) begin
                cfg_we = 1'($urandom);
                cfg_idx = ($urandom_range(1) == 1) ? cur_layer : IW'($urandom_range(NL - 1));
                cfg_flen = 6'($urandom);
                cfg_in_channel = 9'($urandom);
                go = ($urandom_range(3) == 0);
            end else begin
                cfg_we = 1'b0;
                go = 1'b0;
            end
            step();
            t++;
        end
        cfg_we = 1'b0;
        go = 1'b0;
        check({tag, ":finished"}, 64'(done_high > 0 && !busy), 64'd1);
        check({tag, ":starts"}, 64'(starts), 64'(num));
        check({tag, ":run_done_cycles"}, 64'(done_high), 64'd1);
        check({tag, ":total_cycles"}, 64'(total_cycles), 64'(busy_cycles));
        check({tag, ":err"}, 64'(err), 64'd0);
    endtask

    task automatic wait_start(input string tag);
        int t;
        t = 0;
        while (!pool_start && t < 50) begin
            step();
            t++;
        end
        check({tag, ":start_seen"}, 64'(pool_start), 64'd1);
    endtask

    initial begin
        int t, drop_t, idle_t;
        do_reset("reset");

        // Two-layer run with a 10-cycle engine
        write_slot(0, 32, 3);
        write_slot(1, 16, 64);
        run_layers(2, 10, 0, 1'b0, "basic");

        // Bad layer counts raise err without starting
        starts = 0;
        cfg_num = '0;
        go = 1'b1;
        step();
        go = 1'b0;
        check("num0:err", 64'(err), 64'd1);
        check("num0:busy", 64'(busy), 64'd0);
        step();
        step();
        check("num0:no_start", 64'(starts), 64'd0);
        cfg_num = NW'(NL + 1);
        go = 1'b1;
        step();
        go = 1'b0;
        check("num_big:err", 64'(err), 64'd1);
        check("num_big:busy", 64'(busy), 64'd0);
        begin_run(2, 3, 1);
        check("recover:err_cleared", 64'(err), 64'd0);
        check("recover:busy", 64'(busy), 64'd1);
        t = 0;
        while (!(done_high > 0 && !busy) && t < 500) begin
            step();
            t++;
        end
        check("recover:run_done", 64'(done_high), 64'd1);
        check("recover:starts", 64'(starts), 64'd2);

        // go and abort together in IDLE: abort wins
        starts = 0;
        cfg_num = NW'(2);
        go = 1'b1;
        abort = 1'b1;
        step();
        go = 1'b0;
        abort = 1'b0;
        check("go_abort:busy", 64'(busy), 64'd0);
        step();
        check("go_abort:no_start", 64'(starts), 64'd0);

        // Abort in layer 1 WAIT while the engine holds done for 3 cycles
        write_slot(2, 7, 300);
        begin_run(3, 4, 3);
        t = 0;
        while (!(starts == 2 && pool_done) && t < 200) begin
            step();
            t++;
        end
        check("abort:reached_layer1_done", 64'(starts == 2 && pool_done && pool_start), 64'd1);
        check("abort:cur_layer", 64'(cur_layer), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort:start_low", 64'(pool_start), 64'd0);
        check("abort:still_busy", 64'(busy), 64'd1);
        t = 0;
        drop_t = -1;
        idle_t = -1;
        while (t < 100) begin
            step();
            if (!busy) begin
                idle_t = t;
                break;
            end
            if (!pool_done && drop_t < 0) drop_t = t;
            t++;
        end
        check("abort:idle_after_drain", 64'(idle_t), 64'(drop_t + 1));
        check("abort:no_run_done", 64'(done_high), 64'd0);
        check("abort:starts", 64'(starts), 64'd2);
        exp_flen_q.delete();
        exp_ch_q.delete();

        // Randomized tables and runs with ignored writes/go during each run
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < 3; w++) begin
                if ($urandom_range(1) == 1)
                    write_slot(int'($urandom_range(NL - 1)), int'($urandom_range(63)),
                               int'($urandom_range(511)));
            end
            run_layers(int'($urandom_range(NL, 1)), int'($urandom_range(9)),
                       int'($urandom_range(3)), 1'b1, "rand");
        end

        // Reset in the middle of WAIT, then read the table back through a run
        write_slot(0, 45, 200);
        write_slot(1, 9, 17);
        begin_run(2, 10, 0);
        wait_start("midreset");
        step();
        step();
        do_reset("midreset");
        run_layers(NL, 1, 0, 1'b0, "readback");

        // Engine that never answers
        write_slot(0, 5, 6);
        eng_dead = 1'b1;
        begin_run(1, 0, 0);
        wait_start("hang");
`ifdef POOL_SEQ_TIMEOUT_EN
        for (int i = 0; i < 14; i++) step();
        check("timeout:err_not_yet", 64'(err), 64'd0);
        step();
        check("timeout:err", 64'(err), 64'd1);
        check("timeout:busy", 64'(busy), 64'd0);
        check("timeout:pool_start", 64'(pool_start), 64'd0);
        eng_dead = 1'b0;
        run_layers(1, 2, 0, 1'b0, "after_timeout");
`else
        for (int i = 0; i < 100; i++) step();
        check("hang:busy", 64'(busy), 64'd1);
        check("hang:err", 64'(err), 64'd0);
        check("hang:pool_start", 64'(pool_start), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            step();
            t++;
        end
        check("hang:abort_idle", 64'(busy), 64'd0);
        check("hang:no_run_done", 64'(done_high), 64'd0);
        eng_dead = 1'b0;
        run_layers(1, 2, 0, 1'b0, "after_hang");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
